run_ctrl: RTL and testbench
===========================

# run_ctrl

Run-sequencing controller that sits on the producer side of the idle/done status interface. It accepts a one-cycle start command carrying an operation count, then counts datapath step acknowledgements. It generates the registered `idle_o` / `done_o` status pair consumed by the downstream status-capture stage, plus `run_o` and a progress count.

## Interface
Parameters:
- `CNT_WIDTH`, 8, width of the operation count and progress counter.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  start command; sampled only in IDLE.
- `num_cnt_i`  in  CNT_WIDTH  number of steps to run; sampled with `start_i`.
- `step_i`  in  1  datapath step acknowledge; one step completes per high cycle in RUN.
- `abort_i`  in  1  abort request; present only with `RUN_CTRL_ABORT_EN`.
- `run_o`  out  1  high while in RUN; drives the datapath enable.
- `cnt_o`  out  CNT_WIDTH  number of steps completed in the current run.
- `idle_o`  out  1  high in IDLE.
- `done_o`  out  1  one-cycle pulse on completion.

## Operation
- The FSM has three states: S_IDLE, S_RUN and S_DONE. All outputs are registered and decoded from state (Moore).
- S_IDLE:
  - `idle_o`=1.
  - `start_i`=1 with `num_cnt_i`≠0: latch `num_cnt_i` into `num_q`, clear `cnt_o`, go to S_RUN.
  - `start_i`=1 with `num_cnt_i`=0: go directly to S_DONE (empty run).
- S_RUN:
  - `run_o`=1.
  - `step_i`=1: `cnt_o` increments by 1.
  - `step_i`=1 and `cnt_o`==`num_q`-1: `cnt_o` becomes `num_q`, go to S_DONE.
  - `step_i`=0: hold.
  - `start_i` is ignored.
- S_DONE:
  - `done_o`=1 for exactly one cycle, then go to S_IDLE unconditionally.
  - `cnt_o` holds its final value until the next accepted start.
- Arithmetic: `cnt_o` never exceeds `num_q` ≤ 2^CNT_WIDTH−1, so no wrap is possible. Comparison is unsigned at CNT_WIDTH.
- `start_i` asserted in S_DONE is dropped; no queuing.
- `step_i` outside S_RUN is ignored.

## Timing
- Reset values: state=S_IDLE, `idle_o`=1, `done_o`=0, `run_o`=0, `cnt_o`=0, `num_q`=0.
- Start accepted at edge T: `idle_o`=0 and `run_o`=1 from T+1.
- With `step_i` held high and N steps:
  - last step is sampled at edge T+N;
  - `done_o`=1 during cycle T+N+1;
  - `idle_o`=1 from T+N+2.
- Empty run (N=0): `done_o` in cycle T+1, `idle_o` in cycle T+2. `run_o` never asserts.
- `rst` has priority over every other input. `rst` asserted mid-run returns the block to reset values at the next edge.
- Back-to-back runs: earliest restart is the first S_IDLE cycle after `done_o`.

## Configuration
- `RUN_CTRL_ABORT_EN` defined:
  - `abort_i` exists.
  - `abort_i`=1 in S_RUN goes to S_IDLE at the next edge and clears `cnt_o`. `done_o` is not asserted.
  - Abort has priority over `step_i`, including on the final step.
  - `abort_i` is ignored in S_IDLE and S_DONE.
- `RUN_CTRL_ABORT_EN` undefined:
  - no `abort_i` port.
  - S_RUN exits only by completion or `rst`.

## Structure
- Shared package holds:
  - state encoding localparams: S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10;
  - default `CNT_WIDTH`.
- The FSM lives in the top. One sub-module is natural: `step_counter`, holding the counter, clear, increment-enable and terminal-count compare against `num_q`. It outputs `cnt_o` and `last_o`.

## Test plan
- Reset: assert `rst` for 2 cycles → `idle_o`=1, `done_o`=0, `run_o`=0, `cnt_o`=0.
- Normal run: `start_i` pulse with `num_cnt_i`=5, `step_i` held high → `run_o` high for 5 cycles, `cnt_o` counts 1..5, `done_o` pulses once, `idle_o` returns 1 one cycle later.
- Throttled steps: `num_cnt_i`=3, `step_i` pattern 1,0,0,1,0,1 → `cnt_o` holds during the gaps, `done_o` follows the 6th RUN cycle.
- Empty run: `num_cnt_i`=0 → `done_o` at T+1, `run_o` never high, `cnt_o`=0.
- Interference: in RUN (`num_cnt_i`=4), pulse `start_i` with `num_cnt_i`=9 → ignored, run completes at `cnt_o`=4. Then pulse `rst` mid-run of a second start → reset values at the next edge, no `done_o`.
- With `RUN_CTRL_ABORT_EN` defined: `num_cnt_i`=4, assert `abort_i` together with the 4th `step_i` → S_IDLE, `cnt_o`=0, no `done_o` pulse.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared definitions for the run-sequencing controller:
//   - state encodings and the FSM state type
//   - default width of the operation count / progress counter
// ----------------------------------------------------------------------------
package run_ctrl_pkg;

    localparam int CNT_WIDTH_DEF = 8;

    localparam logic [1:0] ENC_IDLE = 2'b00;
    localparam logic [1:0] ENC_RUN  = 2'b01;
    localparam logic [1:0] ENC_DONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ENC_IDLE,
        S_RUN  = ENC_RUN,
        S_DONE = ENC_DONE
    } state_t;

endpackage

// File: rtl/run_ctrl_if.sv
// ----------------------------------------------------------------------------
// run_ctrl_if
// Command / status bundle of run_ctrl.
//   start_i    start command, sampled only in IDLE
//   num_cnt_i  number of steps to run, sampled with start_i
//   step_i     datapath step acknowledge
//   abort_i    abort request (only when RUN_CTRL_ABORT_EN is defined)
//   run_o      high while running (datapath enable)
//   cnt_o      steps completed in the current run
//   idle_o     high while idle
//   done_o     one-cycle completion pulse
// Modports: master drives commands and observes status; slave is run_ctrl.
// ----------------------------------------------------------------------------
interface run_ctrl_if import run_ctrl_pkg::*; #(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) ();

    logic                 start_i;
    logic [CNT_WIDTH-1:0] num_cnt_i;
    logic                 step_i;
`ifdef RUN_CTRL_ABORT_EN
    logic                 abort_i;
`endif
    logic                 run_o;
    logic [CNT_WIDTH-1:0] cnt_o;
    logic                 idle_o;
    logic                 done_o;

`ifdef RUN_CTRL_ABORT_EN
    modport master (
        output start_i, num_cnt_i, step_i, abort_i,
        input  run_o, cnt_o, idle_o, done_o
    );
    modport slave (
        input  start_i, num_cnt_i, step_i, abort_i,
        output run_o, cnt_o, idle_o, done_o
    );
`else
    modport master (
        output start_i, num_cnt_i, step_i,
        input  run_o, cnt_o, idle_o, done_o
    );
    modport slave (
        input  start_i, num_cnt_i, step_i,
        output run_o, cnt_o, idle_o, done_o
    );
`endif

endinterface

// File: rtl/run_ctrl_step_counter.sv
// ----------------------------------------------------------------------------
// step_counter
// Progress counter for run_ctrl: clears on clr_i, increments on inc_i and
// flags the terminal count (the next increment completes the run).
//   clk, rst  clock and synchronous active-high reset
//   clr_i     clear counter to 0 (priority over inc_i)
//   inc_i     increment by 1
//   num_i     latched operation count of the current run
//   cnt_o     steps completed so far
//   last_o    cnt_o == num_i - 1
// ----------------------------------------------------------------------------
module step_counter import run_ctrl_pkg::*; #(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic [CNT_WIDTH-1:0] num_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 last_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Only consulted in RUN, where num_i >= 1, so the subtraction never wraps.
    assign last_o = (cnt_q == (num_i - CNT_WIDTH'(1)));
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/run_ctrl.sv
// ----------------------------------------------------------------------------
// run_ctrl
// Run-sequencing controller. Accepts a start command with an operation count,
// counts step acknowledges while running and produces registered idle/done
// status, a run enable and the progress count.
//   clk   system clock (rising edge)
//   rst   synchronous active-high reset
//   bus   run_ctrl_if.slave: start_i, num_cnt_i, step_i, [abort_i],
//         run_o, cnt_o, idle_o, done_o
// Optional feature: define RUN_CTRL_ABORT_EN to add abort_i, which returns a
// running block to IDLE with the count cleared and no done pulse.
// ----------------------------------------------------------------------------
module run_ctrl import run_ctrl_pkg::*; #(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input logic       clk,
    input logic       rst,
    run_ctrl_if.slave bus
);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic                 idle_q, run_q, done_q;
    logic                 cnt_clr, cnt_inc, cnt_last;
    logic [CNT_WIDTH-1:0] cnt;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // An empty run also clears the count so cnt_o reads 0 for it.
                if (bus.start_i) begin
                    num_d   = bus.num_cnt_i;
                    cnt_clr = 1'b1;
                    state_d = (bus.num_cnt_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
`ifdef RUN_CTRL_ABORT_EN
                // Abort wins over a coincident step, even the final one.
                if (bus.abort_i) begin
                    cnt_clr = 1'b1;
                    state_d = S_IDLE;
                end else
`endif
                if (bus.step_i) begin
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flops are loaded from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            idle_q  <= 1'b1;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            idle_q  <= (state_d == S_IDLE);
            run_q   <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    step_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_step_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .num_i  (num_q),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    assign bus.cnt_o  = cnt;
    assign bus.idle_o = idle_q;
    assign bus.run_o  = run_q;
    assign bus.done_o = done_q;

endmodule

// File: tb/tb_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_run_ctrl
// Directed self-checking bench for run_ctrl. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_run_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    run_ctrl_if #(.CNT_WIDTH(W)) bus ();

    run_ctrl #(.CNT_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", bus.idle_o); end
        checks++;
        if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
        checks++;
        if (bus.run_o !== 1'b0) begin errors++; $display("FAIL reset_run got %b want 0", bus.run_o); end
        checks++;
        if (bus.cnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.cnt_o); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.idle_o !== 1'b1) begin errors++; $display("FAIL post_reset_idle got %b want 1", bus.idle_o); end
    endtask

    task automatic test_normal();
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd5;
        bus.step_i    = 1'b1;
        tick();
        bus.start_i = 1'b0;
        checks++;
        if (bus.run_o !== 1'b1 || bus.idle_o !== 1'b0 || bus.cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL normal_start run=%b idle=%b cnt=%0d want run=1 idle=0 cnt=0",
                     bus.run_o, bus.idle_o, bus.cnt_o);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (bus.cnt_o !== 8'(i) || bus.run_o !== (i < 5) || bus.done_o !== (i == 5)) begin
                errors++;
                $display("FAIL normal_step%0d cnt=%0d run=%b done=%b want cnt=%0d run=%b done=%b",
                         i, bus.cnt_o, bus.run_o, bus.done_o, i, (i < 5), (i == 5));
            end
        end
        tick();
        checks++;
        if (bus.idle_o !== 1'b1 || bus.done_o !== 1'b0 || bus.cnt_o !== 8'd5) begin
            errors++;
            $display("FAIL normal_end idle=%b done=%b cnt=%0d want idle=1 done=0 cnt=5",
                     bus.idle_o, bus.done_o, bus.cnt_o);
        end
        // step while idle must not move the count
        tick();
        bus.step_i = 1'b0;
        checks++;
        if (bus.cnt_o !== 8'd5 || bus.run_o !== 1'b0) begin
            errors++;
            $display("FAIL normal_idle_step cnt=%0d run=%b want cnt=5 run=0", bus.cnt_o, bus.run_o);
        end
    endtask

    task automatic test_throttled();
        logic       pat [6];
        logic [7:0] exp_cnt;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_cnt = 8'd0;
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd3;
        bus.step_i    = 1'b0;
        tick();
        bus.start_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.step_i = pat[k];
            if (pat[k]) exp_cnt = exp_cnt + 8'd1;
            tick();
            checks++;
            if (bus.cnt_o !== exp_cnt || bus.done_o !== (k == 5) || bus.run_o !== (k < 5)) begin
                errors++;
                $display("FAIL throttle_cyc%0d cnt=%0d done=%b run=%b want cnt=%0d done=%b run=%b",
                         k + 1, bus.cnt_o, bus.done_o, bus.run_o, exp_cnt, (k == 5), (k < 5));
            end
        end
        bus.step_i = 1'b0;
        tick();
        checks++;
        if (bus.idle_o !== 1'b1 || bus.done_o !== 1'b0 || bus.cnt_o !== 8'd3) begin
            errors++;
            $display("FAIL throttle_end idle=%b done=%b cnt=%0d want idle=1 done=0 cnt=3",
                     bus.idle_o, bus.done_o, bus.cnt_o);
        end
    endtask

    task automatic test_empty();
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd0;
        tick();
        bus.start_i = 1'b0;
        checks++;
        if (bus.done_o !== 1'b1 || bus.run_o !== 1'b0 || bus.idle_o !== 1'b0 || bus.cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL empty_done done=%b run=%b idle=%b cnt=%0d want done=1 run=0 idle=0 cnt=0",
                     bus.done_o, bus.run_o, bus.idle_o, bus.cnt_o);
        end
        tick();
        checks++;
        if (bus.idle_o !== 1'b1 || bus.done_o !== 1'b0 || bus.run_o !== 1'b0) begin
            errors++;
            $display("FAIL empty_idle idle=%b done=%b run=%b want idle=1 done=0 run=0",
                     bus.idle_o, bus.done_o, bus.run_o);
        end
    endtask

    task automatic test_interference();
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd4;
        bus.step_i    = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();                              // cnt 1
        bus.start_i   = 1'b1;                // ignored in RUN
        bus.num_cnt_i = 8'd9;
        tick();                              // cnt 2
        bus.start_i = 1'b0;
        tick();                              // cnt 3
        tick();                              // cnt 4, done
        checks++;
        if (bus.done_o !== 1'b1 || bus.cnt_o !== 8'd4) begin
            errors++;
            $display("FAIL interf_done done=%b cnt=%0d want done=1 cnt=4", bus.done_o, bus.cnt_o);
        end
        // start during DONE is dropped
        bus.step_i    = 1'b0;
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd2;
        tick();
        bus.start_i = 1'b0;
        tick();
        checks++;
        if (bus.idle_o !== 1'b1 || bus.run_o !== 1'b0 || bus.cnt_o !== 8'd4) begin
            errors++;
            $display("FAIL interf_done_start idle=%b run=%b cnt=%0d want idle=1 run=0 cnt=4",
                     bus.idle_o, bus.run_o, bus.cnt_o);
        end
        // reset mid-run
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd7;
        bus.step_i    = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.cnt_o !== 8'd2 || bus.run_o !== 1'b1) begin
            errors++;
            $display("FAIL interf_prerst cnt=%0d run=%b want cnt=2 run=1", bus.cnt_o, bus.run_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.step_i = 1'b0;
        checks++;
        if (bus.idle_o !== 1'b1 || bus.run_o !== 1'b0 || bus.done_o !== 1'b0 || bus.cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL interf_rst idle=%b run=%b done=%b cnt=%0d want idle=1 run=0 done=0 cnt=0",
                     bus.idle_o, bus.run_o, bus.done_o, bus.cnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.done_o !== 1'b0 || bus.idle_o !== 1'b1) begin
                errors++;
                $display("FAIL interf_after_rst%0d done=%b idle=%b want done=0 idle=1",
                         i, bus.done_o, bus.idle_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd1;
        bus.step_i    = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        checks++;
        if (bus.done_o !== 1'b1 || bus.cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL b2b_done1 done=%b cnt=%0d want done=1 cnt=1", bus.done_o, bus.cnt_o);
        end
        tick();
        checks++;
        if (bus.idle_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle got %b want 1", bus.idle_o);
        end
        // restart in the first idle cycle
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd2;
        tick();
        bus.start_i = 1'b0;
        checks++;
        if (bus.run_o !== 1'b1 || bus.cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL b2b_restart run=%b cnt=%0d want run=1 cnt=0", bus.run_o, bus.cnt_o);
        end
        tick();
        tick();
        checks++;
        if (bus.done_o !== 1'b1 || bus.cnt_o !== 8'd2) begin
            errors++;
            $display("FAIL b2b_done2 done=%b cnt=%0d want done=1 cnt=2", bus.done_o, bus.cnt_o);
        end
        bus.step_i = 1'b0;
        tick();
    endtask

    task automatic test_max_count();
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd255;
        bus.step_i    = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 1; i < 255; i++) tick();
        checks++;
        if (bus.cnt_o !== 8'd254 || bus.run_o !== 1'b1 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL max_pre cnt=%0d run=%b done=%b want cnt=254 run=1 done=0",
                     bus.cnt_o, bus.run_o, bus.done_o);
        end
        tick();
        checks++;
        if (bus.cnt_o !== 8'd255 || bus.done_o !== 1'b1) begin
            errors++;
            $display("FAIL max_done cnt=%0d done=%b want cnt=255 done=1", bus.cnt_o, bus.done_o);
        end
        bus.step_i = 1'b0;
        tick();
    endtask

`ifdef RUN_CTRL_ABORT_EN
    task automatic test_abort();
        bus.start_i   = 1'b1;
        bus.num_cnt_i = 8'd4;
        bus.step_i    = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus.cnt_o !== 8'd3 || bus.run_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre cnt=%0d run=%b want cnt=3 run=1", bus.cnt_o, bus.run_o);
        end
        bus.abort_i = 1'b1;
        tick();
        bus.abort_i = 1'b0;
        bus.step_i  = 1'b0;
        checks++;
        if (bus.idle_o !== 1'b1 || bus.cnt_o !== 8'd0 || bus.done_o !== 1'b0 || bus.run_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_hit idle=%b cnt=%0d done=%b run=%b want idle=1 cnt=0 done=0 run=0",
                     bus.idle_o, bus.cnt_o, bus.done_o, bus.run_o);
        end
        tick();
        checks++;
        if (bus.done_o !== 1'b0 || bus.idle_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_after done=%b idle=%b want done=0 idle=1", bus.done_o, bus.idle_o);
        end
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.start_i   = 1'b0;
        bus.num_cnt_i = '0;
        bus.step_i    = 1'b0;
`ifdef RUN_CTRL_ABORT_EN
        bus.abort_i   = 1'b0;
`endif
        test_reset();
        test_normal();
        test_throttled();
        test_empty();
        test_interference();
        test_back_to_back();
        test_max_count();
`ifdef RUN_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
